// File: rtl/avr_cmd_master.sv
// Command-bus initiator: expands single-beat requests into timed avr_ctrl code sequences.
// Latency: first code the cycle after accept, rsp_valid the cycle after the last code; busy requests are dropped.
module avr_cmd_master #(
    parameter int ADDR_W  = 21,
    parameter int HOLD    = 2,
    parameter int RD_WAIT = 7,
    parameter int WR_WAIT = 5
) (
    input  logic              avr_clk,
    input  logic              avr_reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [7:0]        rsp_rdata,
    output logic [7:0]        avr_ctrl,
    output logic [7:0]        avr_data_out,
    output logic              avr_data_oe,
    input  logic [7:0]        avr_data_in
);

    localparam int MAXW = (HOLD > RD_WAIT) ? ((HOLD > WR_WAIT) ? HOLD : WR_WAIT)
                                           : ((RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT);
    localparam int CW = $clog2(MAXW + 1);
    localparam int BW = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_RESET = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_WRITE = 3'd3;
    localparam logic [2:0] OP_INC   = 3'd4;
    localparam logic [2:0] OP_SNES  = 3'd5;

    localparam logic [7:0] C_IDLE = 8'h01;

    logic [1:0]        state;
    logic [2:0]        op;
    logic [2:0]        step;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rd_hold;

    function automatic logic [7:0] code_of(input logic [2:0] o, input logic [2:0] s, input logic si);
        logic [7:0] c;
        c = 8'h10;
        case (o)
            OP_RESET: case (s)
                3'd0:    c = 8'h03;
                3'd1:    c = 8'h0F;
                3'd2:    c = 8'h02;
                3'd3:    c = 8'h09;
                3'd4:    c = 8'h0C;
                default: c = 8'h0E;
            endcase
            OP_LOAD:  c = (s == 3'd0) ? 8'h04 : ((s == 3'd1) ? (si ? 8'h07 : 8'h06) : 8'h05);
            OP_READ:  c = (s == 3'd0) ? 8'h08 : 8'h09;
            OP_WRITE: c = (s == 3'd0) ? 8'h0A : 8'h0C;
            OP_INC:   c = (s == 3'd0) ? 8'h0D : 8'h0E;
            default:  c = 8'h10;
        endcase
        return c;
    endfunction

    // Terminal count of the hold/wait counter for a given step.
    function automatic logic [CW-1:0] last_cnt(input logic [2:0] o, input logic [2:0] s);
        logic [CW-1:0] l;
        l = CW'(HOLD - 1);
        if (o == OP_READ && s == 3'd0)  l = CW'(RD_WAIT - 1);
        if (o == OP_WRITE && s == 3'd0) l = CW'(WR_WAIT - 1);
        return l;
    endfunction

    function automatic logic [2:0] last_step(input logic [2:0] o);
        logic [2:0] l;
        case (o)
            OP_RESET:                 l = 3'd5;
            OP_LOAD:                  l = 3'd2;
            OP_READ, OP_WRITE, OP_INC: l = 3'd1;
            default:                  l = 3'd0;
        endcase
        return l;
    endfunction

    logic          step_end;
    logic          si_loop;
    logic [2:0]    nxt_step;
    logic [BW-1:0] nxt_bit;

    // The SI step repeats once per address bit before moving on to SREG_EN_HI.
    always_comb begin
        step_end = (cnt == last_cnt(op, step));
        si_loop  = (op == OP_LOAD) && (step == 3'd1) && (bit_idx != '0);
        nxt_step = si_loop ? step : step + 3'd1;
        nxt_bit  = si_loop ? bit_idx - 1'b1 : bit_idx;
    end

    assign req_ready = (state == S_IDLE);

    always_ff @(posedge avr_clk) begin
        if (!avr_reset_n) begin
            state        <= S_IDLE;
            op           <= '0;
            step         <= '0;
            cnt          <= '0;
            bit_idx      <= '0;
            addr         <= '0;
            rd_hold      <= '0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            avr_ctrl     <= C_IDLE;
            avr_data_out <= '0;
            avr_data_oe  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    if (req_valid) begin
                        op      <= req_op;
                        addr    <= req_addr;
                        step    <= '0;
                        cnt     <= '0;
                        bit_idx <= BW'(ADDR_W - 1);
                        if (req_op > OP_SNES) begin
                            state     <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state    <= S_RUN;
                            avr_ctrl <= code_of(req_op, 3'd0, 1'b0);
                            if (req_op == OP_WRITE) begin
                                avr_data_oe  <= 1'b1;
                                avr_data_out <= req_wdata;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (step_end) begin
                        cnt <= '0;
                        if (op == OP_READ && step == 3'd0)
                            rd_hold <= avr_data_in;
                        if (op == OP_WRITE && step == 3'd0)
                            avr_data_oe <= 1'b0;
                        if (step == last_step(op) && !si_loop) begin
                            state     <= S_DONE;
                            avr_ctrl  <= C_IDLE;
                            rsp_valid <= 1'b1;
                            if (op == OP_READ)
                                rsp_rdata <= rd_hold;
                        end else begin
                            step     <= nxt_step;
                            bit_idx  <= nxt_bit;
                            avr_ctrl <= code_of(op, nxt_step, addr[nxt_bit]);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avr_cmd_master.sv
// Bench for avr_cmd_master: directed bring-up cases then random ops, each checked against a
// per-cycle code list built from the command-sequence rules.
module tb_avr_cmd_master;

    localparam int ADDR_W  = 21;
    localparam int HOLD    = 2;
    localparam int RD_WAIT = 7;
    localparam int WR_WAIT = 5;

    logic              avr_clk = 1'b0;
    logic              avr_reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [7:0]        rsp_rdata;
    logic [7:0]        avr_ctrl;
    logic [7:0]        avr_data_out;
    logic              avr_data_oe;
    logic [7:0]        avr_data_in;

    avr_cmd_master #(.ADDR_W(ADDR_W), .HOLD(HOLD), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .avr_clk(avr_clk), .avr_reset_n(avr_reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .avr_ctrl(avr_ctrl), .avr_data_out(avr_data_out), .avr_data_oe(avr_data_oe),
        .avr_data_in(avr_data_in)
    );

    always #5 avr_clk = ~avr_clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_rdata;
    logic [7:0] exp_ctrl[$];
    bit         exp_oe[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] code, input int n, input bit oe);
        for (int k = 0; k < n; k++) begin
            exp_ctrl.push_back(code);
            exp_oe.push_back(oe);
        end
    endtask

    // Expected avr_ctrl/oe per cycle, flattened from the sequence table.
    task automatic build(input logic [2:0] op, input logic [ADDR_W-1:0] a);
        logic [7:0] rst_seq [6];
        rst_seq = '{8'h03, 8'h0F, 8'h02, 8'h09, 8'h0C, 8'h0E};
        exp_ctrl.delete();
        exp_oe.delete();
        case (op)
            3'd0: for (int k = 0; k < 6; k++) push(rst_seq[k], HOLD, 1'b0);
            3'd1: begin
                push(8'h04, HOLD, 1'b0);
                for (int b = ADDR_W - 1; b >= 0; b--) push(a[b] ? 8'h07 : 8'h06, HOLD, 1'b0);
                push(8'h05, HOLD, 1'b0);
            end
            3'd2: begin push(8'h08, RD_WAIT, 1'b0); push(8'h09, HOLD, 1'b0); end
            3'd3: begin push(8'h0A, WR_WAIT, 1'b1); push(8'h0C, HOLD, 1'b0); end
            3'd4: begin push(8'h0D, HOLD, 1'b0); push(8'h0E, HOLD, 1'b0); end
            3'd5: push(8'h10, HOLD, 1'b0);
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [ADDR_W-1:0] a,
                          input logic [7:0] wd, input logic [7:0] din, input bit hold);
        int n;
        build(op, a);
        n = exp_ctrl.size();
        @(negedge avr_clk);
        chk("ready_idle", req_ready, 1);
        chk("rsp_idle", rsp_valid, 0);
        avr_data_in = din;
        req_valid = 1'b1;
        req_op = op;
        req_addr = a;
        req_wdata = wd;
        @(posedge avr_clk);
        #1;
        if (!hold) req_valid = 1'b0;
        req_addr = ADDR_W'($urandom);
        req_wdata = 8'($urandom);
        for (int i = 0; i < n; i++) begin
            @(negedge avr_clk);
            chk("ctrl", avr_ctrl, exp_ctrl[i]);
            chk("oe", avr_data_oe, exp_oe[i]);
            if (exp_oe[i]) chk("wdata", avr_data_out, wd);
            chk("busy", req_ready, 0);
            chk("rsp_early", rsp_valid, 0);
        end
        @(negedge avr_clk);
        req_valid = 1'b0;
        if (op == 3'd2) model_rdata = din;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, (op > 3'd5) ? 1 : 0);
        chk("done_ctrl", avr_ctrl, 8'h01);
        chk("done_oe", avr_data_oe, 0);
        chk("rdata", rsp_rdata, model_rdata);
    endtask

    initial begin
        avr_reset_n = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_addr = '0;
        req_wdata = '0;
        avr_data_in = '0;
        model_rdata = 8'h00;
        repeat (3) @(negedge avr_clk);
        chk("rst_ctrl", avr_ctrl, 8'h01);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_oe", avr_data_oe, 0);
        chk("rst_dout", avr_data_out, 8'h00);
        avr_reset_n = 1'b1;

        run_op(3'd0, '0, 8'h00, 8'h00, 1'b0);
        run_op(3'd1, 21'h04CCF, 8'h00, 8'h00, 1'b0);
        run_op(3'd2, '0, 8'h00, 8'hAA, 1'b0);
        run_op(3'd2, '0, 8'h00, 8'hBB, 1'b0);
        run_op(3'd3, '0, 8'hEE, 8'h00, 1'b0);
        run_op(3'd4, '0, 8'h00, 8'h00, 1'b0);
        run_op(3'd7, '0, 8'h00, 8'h00, 1'b0);
        run_op(3'd5, '0, 8'h00, 8'h00, 1'b0);

        // Request held high through a whole LOAD must produce one operation only.
        run_op(3'd1, 21'h1A5F3, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge avr_clk);
            chk("held_ready", req_ready, 1);
            chk("held_ctrl", avr_ctrl, 8'h01);
        end

        // Reset in the middle of the WE_LO window aborts the write.
        @(negedge avr_clk);
        req_valid = 1'b1;
        req_op = 3'd3;
        req_wdata = 8'h5C;
        @(posedge avr_clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge avr_clk);
        chk("abort_pre_ctrl", avr_ctrl, 8'h0A);
        chk("abort_pre_oe", avr_data_oe, 1);
        avr_reset_n = 1'b0;
        @(negedge avr_clk);
        avr_reset_n = 1'b1;
        model_rdata = 8'h00;
        chk("abort_ctrl", avr_ctrl, 8'h01);
        chk("abort_oe", avr_data_oe, 0);
        chk("abort_rsp", rsp_valid, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_rdata", rsp_rdata, 8'h00);
        for (int i = 0; i < WR_WAIT + HOLD + 2; i++) begin
            @(negedge avr_clk);
            chk("abort_no_rsp", rsp_valid, 0);
        end

        for (int t = 0; t < 40; t++)
            run_op(3'($urandom_range(0, 7)), ADDR_W'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
